add_arbiter: RTL and testbench

Shares one 32-bit ripple-carry adder (RCA32) among NREQ requesters under round-robin arbitration. Each requester presents two operands and a carry-in with a level request. It receives a one-cycle grant when its operands are captured, and gets the tagged sum on a common result bus two cycles later. The block sits between the ALU-side clients and the single adder instance, at one operation per cycle sustained.

---
 rtl/add_arbiter_if.sv | 41 ++++
 rtl/add_arbiter.sv | 175 +++++++++++++++++
 tb/tb_add_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/operand/grant/result bundle between the ALU-side
// clients (master) and the shared-adder arbiter (slave).
// Optional chain port is present only when ADD_ARB_CHAIN_EN is defined.
interface add_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] a;
  logic [NREQ*32-1:0] b;
  logic [NREQ-1:0]    cin;
`ifdef ADD_ARB_CHAIN_EN
  logic [NREQ-1:0]    chain;
`endif
  logic [NREQ-1:0]    gnt;
  logic               rslt_vld;
  logic [31:0]        rslt_sum;
  logic               rslt_cout;
  logic [IW-1:0]      rslt_id;

`ifdef ADD_ARB_CHAIN_EN
  modport master (
    output req, a, b, cin, chain,
    input  gnt, rslt_vld, rslt_sum, rslt_cout, rslt_id
  );
  modport slave (
    input  req, a, b, cin, chain,
    output gnt, rslt_vld, rslt_sum, rslt_cout, rslt_id
  );
`else
  modport master (
    output req, a, b, cin,
    input  gnt, rslt_vld, rslt_sum, rslt_cout, rslt_id
  );
  modport slave (
    input  req, a, b, cin,
    output gnt, rslt_vld, rslt_sum, rslt_cout, rslt_id
  );
`endif
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one 32-bit ripple-carry adder among
// NREQ requesters. Grant and operand capture in cycle T, add in T+1,
// tagged result on the common bus in T+2; one operation per cycle.
// Optional feature macro: ADD_ARB_CHAIN_EN (chain lock with carry forwarding
// for multi-word adds). Default build has no chain port and no lock state.
module add_arbiter #(
  parameter int NREQ = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  add_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  // 32-bit ripple-carry adder; returns {cout, sum}
  function automatic logic [32:0] rca32(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        ci);
    logic [31:0] s;
    logic        c;
    c = ci;
    s = '0;
    for (int k = 0; k < 32; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    return {c, s};
  endfunction

  // Pointer advance with wrap at NREQ (NREQ need not be a power of two)
  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] id);
    if (id == IW'(NREQ - 1)) return '0;
    return id + IW'(1);
  endfunction

  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] gnt_c;
  logic            gnt_any;
  logic [IW-1:0]   gnt_id;
  logic            lock_hit;
  logic [IW-1:0]   lock_sel;
  logic            chain_sel;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic            cin_sel;
  logic            cin_cap;

  logic [31:0]     a_p1;
  logic [31:0]     b_p1;
  logic            cin_p1;
  logic [IW-1:0]   id_p1;
  logic            vld_p1;
  logic [32:0]     add_p1;

`ifdef ADD_ARB_CHAIN_EN
  logic            lock_vld;
  logic [IW-1:0]   lock_id;

  // A live lock only wins while its owner keeps requesting
  assign lock_hit  = lock_vld && bus.req[lock_id];
  assign lock_sel  = lock_id;
`else
  assign lock_hit  = 1'b0;
  assign lock_sel  = '0;
`endif

  // Grant search: locked owner first, otherwise first requester at/after ptr
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    idx_w   = '0;
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_id  = lock_sel;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        idx_w = IW'(idx);
        if (!gnt_any && bus.req[idx_w]) begin
          gnt_any = 1'b1;
          gnt_id  = idx_w;
        end
      end
    end
  end

  // One-hot grant vector and operand selection for the winner
  always_comb begin
    gnt_c     = '0;
    a_sel     = '0;
    b_sel     = '0;
    cin_sel   = 1'b0;
    chain_sel = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IW'(k)) begin
        gnt_c[k] = gnt_any;
        a_sel    = bus.a[32*k +: 32];
        b_sel    = bus.b[32*k +: 32];
        cin_sel  = bus.cin[k];
`ifdef ADD_ARB_CHAIN_EN
        chain_sel = bus.chain[k];
`endif
      end
    end
  end

  assign bus.gnt = rst_n ? gnt_c : '0;

  // A locked grant continues the previous word, so its carry comes from the
  // op currently in stage 1 (same requester, granted last cycle).
  assign cin_cap = lock_hit ? add_p1[32] : cin_sel;

  // ---- stage 0 -> stage 1: grant, capture operands ----

  // Round-robin pointer and stage-1 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt_any;
      if (gnt_any && !lock_hit) ptr <= ptr_after(gnt_id);
    end
  end

`ifdef ADD_ARB_CHAIN_EN
  // Chain lock: set by a grant with chain, dropped by chain=0 or no grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= '0;
    end else if (gnt_any) begin
      lock_vld <= chain_sel;
      lock_id  <= gnt_id;
    end else begin
      lock_vld <= 1'b0;
    end
  end
`endif

  // Stage-1 operand registers, loaded only on a grant
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      a_p1   <= a_sel;
      b_p1   <= b_sel;
      cin_p1 <= cin_cap;
      id_p1  <= gnt_id;
    end
  end

  // ---- stage 1 -> stage 2: add, register result ----

  assign add_p1 = rca32(a_p1, b_p1, cin_p1);

  // Result bus: pulse valid per op, hold data between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rslt_vld  <= 1'b0;
      bus.rslt_sum  <= '0;
      bus.rslt_cout <= 1'b0;
      bus.rslt_id   <= '0;
    end else begin
      bus.rslt_vld <= vld_p1;
      if (vld_p1) begin
        bus.rslt_sum  <= add_p1[31:0];
        bus.rslt_cout <= add_p1[32];
        bus.rslt_id   <= id_p1;
      end
    end
  end
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed + randomized stimulus for add_arbiter, checked
// against a transaction-level model (rotation order, plain addition, queue of
// expected results keyed by due cycle).
module tb_add_arbiter;
  localparam int NREQ = 4;
`ifdef ADD_ARB_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_arbiter_if #(.NREQ(NREQ)) bus();
  add_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          due;
    logic [31:0] sum;
    logic        cout;
    int          id;
  } res_t;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  res_t q[$];

  logic [31:0] last_sum;
  logic        last_cout;
  int          last_id;
  int          ptr_m;
  int          lock_m;
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  logic        op_c [NREQ];
  logic        op_ch[NREQ];
  logic        pend [NREQ];
  logic        prev_cout[NREQ];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y,
                        input logic c, input logic ch);
    op_a[i]  = x;
    op_b[i]  = y;
    op_c[i]  = c;
    op_ch[i] = ch & CHAIN_EN;
    pend[i]  = 1'b1;
  endtask

  task automatic set_rand(input int i);
    logic [31:0] x;
    logic [31:0] y;
    x = $urandom;
    y = $urandom;
    if ($urandom_range(0, 5) == 0) x = 32'hFFFF_FFFF;
    if ($urandom_range(0, 5) == 0) y = 32'h0000_0001;
    set_op(i, x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]        = pend[i];
      bus.a[32*i +: 32] = op_a[i];
      bus.b[32*i +: 32] = op_b[i];
      bus.cin[i]        = op_c[i];
`ifdef ADD_ARB_CHAIN_EN
      bus.chain[i]      = op_ch[i];
`endif
    end
  endtask

  // Winner by the arbitration rules: live lock owner, else first in rotation from ptr
  function automatic int exp_grant();
    if (lock_m >= 0 && pend[lock_m]) return lock_m;
    for (int k = 0; k < NREQ; k++)
      if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  // One clock: called just after a falling edge; drives, checks, advances model
  task automatic cycle();
    int              g;
    logic [NREQ-1:0] eg;
    logic [32:0]     s;
    logic            ci;
    logic            locked;
    res_t            r;
    drive();
    #1;
    g  = exp_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("gnt", 64'(bus.gnt), 64'(eg));
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      check("rslt_vld", 64'(bus.rslt_vld), 64'd1);
      check("rslt_sum", 64'(bus.rslt_sum), 64'(r.sum));
      check("rslt_cout", 64'(bus.rslt_cout), 64'(r.cout));
      check("rslt_id", 64'(bus.rslt_id), 64'(r.id));
      last_sum  = r.sum;
      last_cout = r.cout;
      last_id   = r.id;
    end else begin
      check("rslt_vld_idle", 64'(bus.rslt_vld), 64'd0);
      check("rslt_sum_hold", 64'(bus.rslt_sum), 64'(last_sum));
      check("rslt_cout_hold", 64'(bus.rslt_cout), 64'(last_cout));
      check("rslt_id_hold", 64'(bus.rslt_id), 64'(last_id));
    end
    if (g >= 0) begin
      locked = (lock_m >= 0) && (g == lock_m);
      ci     = locked ? prev_cout[g] : op_c[g];
      s      = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {32'd0, ci};
      r.due  = cyc + 2;
      r.sum  = s[31:0];
      r.cout = s[32];
      r.id   = g;
      q.push_back(r);
      prev_cout[g] = s[32];
      if (!locked) ptr_m = (g + 1) % NREQ;
      lock_m  = op_ch[g] ? g : -1;
      pend[g] = 1'b0;
    end else begin
      lock_m = -1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset at a falling edge, check forced/cleared outputs, release two cycles later
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    bus.req = '1;
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_vld", 64'(bus.rslt_vld), 64'd0);
    check("rst_sum", 64'(bus.rslt_sum), 64'd0);
    check("rst_cout", 64'(bus.rslt_cout), 64'd0);
    check("rst_id", 64'(bus.rslt_id), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    last_id   = 0;
    ptr_m     = 0;
    lock_m    = -1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = 1'b0; op_ch[i] = 1'b0;
      pend[i] = 1'b0; prev_cout[i] = 1'b0;
    end
    bus.req = '0; bus.a = '0; bus.b = '0; bus.cin = '0;
`ifdef ADD_ARB_CHAIN_EN
    bus.chain = '0;
`endif
    @(negedge clk);
    do_reset();

    // Single request from 2: 1 + FFFF_FFFF -> sum 0, carry 1
    set_op(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle();
    idle(3);
    check("t1_sum", 64'(bus.rslt_sum), 64'd0);
    check("t1_cout", 64'(bus.rslt_cout), 64'd1);
    check("t1_id", 64'(bus.rslt_id), 64'd2);

    // All requesters continuously busy for 8 cycles
    do_reset();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) set_op(i, 32'(n * 16 + i), 32'h1000_0000 * (i + 1), 1'(n & 1), 1'b0);
      cycle();
    end
    idle(3);

    // ptr moved to 2, then 1 and 3 compete
    do_reset();
    set_op(1, 32'h11, 32'h22, 1'b0, 1'b0);
    cycle();
    idle(2);
    set_op(1, 32'h100, 32'h200, 1'b1, 1'b0);
    set_op(3, 32'h300, 32'h400, 1'b0, 1'b0);
    cycle();
    cycle();
    idle(3);

    // Sparse requests with idle gaps
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, NREQ - 1);
        if (!pend[i]) set_rand(i);
      end
      cycle();
    end
    idle(3);

    // Dense random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) set_rand(i);
      cycle();
    end
    idle(3);

    // Reset one cycle after a grant discards the op
    set_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    cycle();
    do_reset();
    idle(3);
    set_op(0, 32'h5, 32'h6, 1'b0, 1'b0);
    set_op(3, 32'h7, 32'h8, 1'b1, 1'b0);
    cycle();
    cycle();
    idle(3);

`ifdef ADD_ARB_CHAIN_EN
    // Two-word add from requester 0 while requester 1 waits
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    set_op(1, 32'hA, 32'hB, 1'b0, 1'b0);
    cycle();
    set_op(0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    cycle();
    idle(2);
    check("chain_hi_sum", 64'(bus.rslt_sum), 64'h15);
    check("chain_hi_id", 64'(bus.rslt_id), 64'd1);
`endif

    idle(4);
    check("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
